// File: rtl/acc_readout_ctrl.sv
// Drain stage for the Accumulator: walks rows out of the accumulator memories, requantises each
// lane to ACTIVATION_WIDTH and presents rows on a valid/ready stream through a credit-limited FIFO.
module acc_readout_ctrl #(
    parameter int unsigned SYSTOLIC_SIZE     = 8,
    parameter int unsigned WEIGHT_WIDTH      = 8,
    parameter int unsigned ACTIVATION_WIDTH  = 8,
    parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH
                                               + $clog2(SYSTOLIC_SIZE),
    parameter int unsigned PATTERN_NUMBER    = 1,
    parameter int unsigned ADDR_WIDTH        = $clog2(PATTERN_NUMBER * SYSTOLIC_SIZE),
    parameter int unsigned RD_LATENCY        = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [ADDR_WIDTH:0]                           row_count,
    input  logic [4:0]                                    shift_amt,
    input  logic                                          relu_en,
    output logic [ADDR_WIDTH-1:0]                         rd_addr,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]    ps_in,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [ACTIVATION_WIDTH*SYSTOLIC_SIZE-1:0]     out_data,
    output logic                                          out_last,
    output logic                                          busy,
    output logic                                          done
);

    localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W      = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
    localparam int unsigned ROW_W      = ACTIVATION_WIDTH * SYSTOLIC_SIZE;
    localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE_ROW  = (ADDR_WIDTH + 1)'(1);
    localparam logic signed [PARTIAL_SUM_WIDTH-1:0] SAT_MAX =
        PARTIAL_SUM_WIDTH'(2 ** (ACTIVATION_WIDTH - 1) - 1);
    localparam logic signed [PARTIAL_SUM_WIDTH-1:0] SAT_MIN =
        PARTIAL_SUM_WIDTH'(-(2 ** (ACTIVATION_WIDTH - 1)));

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFinish} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     row_cnt_q, row_cnt_d, issue_cnt_q, issue_cnt_d, rc_sat;
    logic [4:0]              shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    issue, issue_last, rd_issue_q, rd_last_q;
    logic [RD_LATENCY-1:0]   vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
    logic [ROW_W:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        fifo_cnt_q;
    logic                    push, pop, head_last;
    logic [ROW_W-1:0]        push_data, head_data;
    logic [CRD_W-1:0]        credit_used;
    logic                    credit_ok;
    logic                    busy_q, done_q;

    function automatic logic [ACTIVATION_WIDTH-1:0] requant(
        input logic signed [PARTIAL_SUM_WIDTH-1:0] ps,
        input logic [4:0]                          sh,
        input logic                                relu
    );
        logic signed [PARTIAL_SUM_WIDTH-1:0] v;
        v = ps >>> sh;
        if (relu && v < 0) v = '0;
        if (v > SAT_MAX) return SAT_MAX[ACTIVATION_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[ACTIVATION_WIDTH-1:0];
        return v[ACTIVATION_WIDTH-1:0];
    endfunction

    assign rc_sat = (row_count > MAX_ROWS) ? MAX_ROWS : row_count;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            push_data[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] =
                requant(ps_in[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH], shift_q, relu_q);
        end
    end

    assign push                   = vld_pipe_q[RD_LATENCY-1];
    assign out_valid              = (fifo_cnt_q != '0);
    assign pop                    = out_valid & out_ready;
    assign {head_last, head_data} = fifo_mem[rd_ptr_q];
    assign out_data               = out_valid ? head_data : '0;
    assign out_last               = out_valid & head_last;
    assign rd_addr                = rd_addr_q;
    assign busy                   = busy_q;
    assign done                   = done_q;

    // Every read on the bus or in the latency pipe already owns a FIFO slot; a same-cycle pop
    // frees one, which is what lets the drain sustain one row per cycle.
    always_comb begin
        credit_used = CRD_W'(fifo_cnt_q) + CRD_W'(rd_issue_q) - CRD_W'(pop);
        for (int i = 0; i < RD_LATENCY; i++) begin
            credit_used = credit_used + CRD_W'(vld_pipe_q[i]);
        end
        credit_ok = (credit_used < CRD_W'(FIFO_DEPTH));
    end

    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = rd_issue_q;
        last_pipe_d[0] = rd_last_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        issue_cnt_d = issue_cnt_q;
        rd_addr_d   = rd_addr_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    row_cnt_d = rc_sat;
                    shift_d   = shift_amt;
                    relu_d    = relu_en;
                    if (rc_sat == '0) begin
                        state_d = StFinish;
                    end else begin
                        issue       = 1'b1;
                        issue_last  = (rc_sat == ONE_ROW);
                        issue_cnt_d = ONE_ROW;
                        rd_addr_d   = '0;
                        state_d     = StRead;
                    end
                end
            end
            StRead: begin
                if (issue_cnt_q == row_cnt_q) begin
                    state_d = StDrain;
                end else if (credit_ok) begin
                    issue       = 1'b1;
                    rd_addr_d   = issue_cnt_q[ADDR_WIDTH-1:0];
                    issue_cnt_d = issue_cnt_q + ONE_ROW;
                    issue_last  = (issue_cnt_d == row_cnt_q);
                    if (issue_last) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && head_last) state_d = StFinish;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            row_cnt_q   <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            issue_cnt_q <= '0;
            rd_addr_q   <= '0;
            rd_issue_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            issue_cnt_q <= issue_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_issue_q  <= issue;
            rd_last_q   <= issue_last;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_q == StFinish);
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {last_pipe_q[RD_LATENCY-1], push_data};
    end

endmodule

// File: tb/tb_acc_readout_ctrl.sv
// Directed bench for acc_readout_ctrl: requantisation vector table plus multi-cycle sequences
// for backpressure, empty drains, abort by reset and ignored restarts.
module tb_acc_readout_ctrl;

    localparam int S   = 8;
    localparam int A   = 8;
    localparam int PSW = 19;
    localparam int AW  = 3;

    logic             clk, rst, start, relu_en;
    logic [AW:0]      row_count;
    logic [4:0]       shift_amt;
    logic [AW-1:0]    rd_addr;
    logic [PSW*S-1:0] ps_in;
    logic             out_valid, out_ready, out_last, busy, done;
    logic [A*S-1:0]   out_data;

    logic signed [PSW-1:0] lane_mem [8][8];

    int          checks, errors, done_c;
    logic [63:0] got_data[$];
    logic        got_last[$];
    int          beat_c[$];

    typedef struct {
        int ps;
        int sh;
        bit rl;
        int expv;
    } vec_t;
    vec_t vecs[16];

    acc_readout_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_count (row_count),
        .shift_amt (shift_amt),
        .relu_en   (relu_en),
        .rd_addr   (rd_addr),
        .ps_in     (ps_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator memory model with one cycle of read latency.
    always_ff @(posedge clk) begin
        for (int i = 0; i < S; i++) ps_in[i*PSW +: PSW] <= lane_mem[rd_addr][i];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ramp_row(input int r);
        logic [63:0] res;
        for (int i = 0; i < S; i++) res[i*A +: A] = 8'(r * 8 + i);
        return res;
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < S; i++) lane_mem[r][i] = 19'(r * 8 + i);
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < S; i++) lane_mem[r][i] = 19'(v);
    endtask

    // Returns at the falling edge of the first cycle after start is accepted.
    task automatic start_drain(input int rc, input int sh, input bit rl);
        @(negedge clk);
        start     = 1'b1;
        row_count = 4'(rc);
        shift_amt = 5'(sh);
        relu_en   = rl;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready 1,0,0,1 then random.
    task automatic collect(input int mode, input int budget, input int restart_c);
        logic [63:0] prev_data;
        logic        prev_last, prev_stall;
        got_data.delete();
        got_last.delete();
        beat_c.delete();
        done_c     = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (mode == 0) out_ready = 1'b1;
            else if (c < 4) out_ready = (c == 0 || c == 3);
            else out_ready = 1'($urandom_range(0, 1));
            start = (c == restart_c);
            if (c == restart_c) begin
                row_count = 4'd2;
                shift_amt = 5'd3;
                relu_en   = 1'b1;
            end
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                beat_c.push_back(c);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_rows(input int n);
        chk("beat_count", got_data.size(), n);
        for (int k = 0; k < got_data.size() && k < n; k++) begin
            chk($sformatf("row%0d_data", k), got_data[k], ramp_row(k));
            chk($sformatf("row%0d_last", k), got_last[k], (k == n - 1));
        end
        chk("done_seen", done_c >= 0, 1);
    endtask

    task automatic finish_idle();
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        logic [63:0] exp_row;
        int          n, seen;
        checks = 0;
        errors = 0;
        vecs[0]  = '{-300, 2, 1'b0, -75};
        vecs[1]  = '{-1000, 2, 1'b0, -128};
        vecs[2]  = '{1000, 2, 1'b0, 127};
        vecs[3]  = '{-5, 0, 1'b1, 0};
        vecs[4]  = '{-5, 0, 1'b0, -5};
        vecs[5]  = '{127, 0, 1'b0, 127};
        vecs[6]  = '{128, 0, 1'b0, 127};
        vecs[7]  = '{-128, 0, 1'b0, -128};
        vecs[8]  = '{-129, 0, 1'b0, -128};
        vecs[9]  = '{50, 1, 1'b1, 25};
        vecs[10] = '{-7, 31, 1'b0, -1};
        vecs[11] = '{7, 31, 1'b0, 0};
        vecs[12] = '{-1, 19, 1'b0, -1};
        vecs[13] = '{200000, 25, 1'b0, 0};
        vecs[14] = '{262143, 10, 1'b0, 127};
        vecs[15] = '{-3, 1, 1'b0, -2};

        rst = 1'b1; start = 1'b0; row_count = '0; shift_amt = '0; relu_en = 1'b0;
        out_ready = 1'b1;
        fill_ramp();
        repeat (3) @(negedge clk);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Full-speed ramp drain.
        start_drain(8, 0, 0);
        chk("t1_busy", busy, 1);
        chk("t1_first_rd_addr", rd_addr, 0);
        collect(0, 40, -1);
        check_rows(8);
        chk("t1_first_beat_cycle", (beat_c.size() > 0) ? beat_c[0] : -1, 2);
        chk("t1_last_beat_cycle", (beat_c.size() > 7) ? beat_c[7] : -1, 9);
        finish_idle();

        // Requantisation table, one single-row drain per entry.
        for (int v = 0; v < 16; v++) begin
            fill_const(vecs[v].ps);
            for (int i = 0; i < S; i++) exp_row[i*A +: A] = 8'(vecs[v].expv);
            start_drain(1, vecs[v].sh, vecs[v].rl);
            collect(0, 20, -1);
            chk($sformatf("vec%0d_beats", v), got_data.size(), 1);
            if (got_data.size() > 0) begin
                chk($sformatf("vec%0d_data", v), got_data[0], exp_row);
                chk($sformatf("vec%0d_last", v), got_last[0], 1);
            end
            chk($sformatf("vec%0d_done", v), done_c >= 0, 1);
            finish_idle();
        end
        fill_ramp();

        // Random backpressure.
        start_drain(8, 0, 0);
        collect(1, 300, -1);
        check_rows(8);
        finish_idle();

        // Credits exhausted: only FIFO_DEPTH reads may issue while the consumer stalls.
        out_ready = 1'b0;
        start_drain(8, 0, 0);
        repeat (10) @(negedge clk);
        chk("stall_rd_addr", rd_addr, 2);
        chk("stall_valid", out_valid, 1);
        chk("stall_head", out_data, ramp_row(0));
        chk("stall_head_last", out_last, 0);
        chk("stall_busy", busy, 1);
        collect(0, 40, -1);
        check_rows(8);
        finish_idle();

        // Empty drain.
        start_drain(0, 0, 0);
        chk("t4_busy", busy, 1);
        chk("t4_no_valid_c0", out_valid, 0);
        collect(0, 20, -1);
        chk("t4_beats", got_data.size(), 0);
        chk("t4_done_cycle", done_c, 1);
        finish_idle();

        // row_count above 2^ADDR_WIDTH saturates.
        start_drain(15, 0, 0);
        collect(0, 40, -1);
        check_rows(8);
        finish_idle();

        // Reset while beat 3 is on the output.
        start_drain(8, 0, 0);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            if (out_valid && out_ready) n++;
            @(negedge clk);
        end
        chk("t5_reached_beat3", n, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rd_addr", rd_addr, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_out_last", out_last, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid) seen++;
        end
        chk("t5_quiet_after_abort", seen, 0);
        start_drain(4, 0, 0);
        collect(0, 30, -1);
        check_rows(4);
        finish_idle();

        // A start pulse mid-drain must be ignored.
        start_drain(8, 0, 0);
        collect(0, 40, 3);
        check_rows(8);
        finish_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
